host_arbiter: RTL and testbench

HOST_ARBITER -- requirements
Module: host_arbiter

---
 rtl/host_arbiter.sv | 161 ++++++++++++++++
 tb/tb_host_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_arbiter.sv
// Round-robin arbiter sharing one downstream bus among NrHosts hosts, one transaction in flight.
// Define HOST_ARB_TIMEOUT_EN to add a response timeout that errors out a stalled transaction.
module host_arbiter #(
    parameter int NrHosts       = 2,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NrHosts-1:0]                host_req_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*4-1:0]              host_be_i,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [DataWidth-1:0]              host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,
    output logic                              dev_req_o,
    output logic                              dev_we_o,
    output logic [3:0]                        dev_be_o,
    output logic [AddressWidth-1:0]           dev_addr_o,
    output logic [DataWidth-1:0]              dev_wdata_o,
    input  logic                              dev_gnt_i,
    input  logic                              dev_rvalid_i,
    input  logic [DataWidth-1:0]              dev_rdata_i,
    input  logic                              dev_err_i
);

    localparam int PtrW = $clog2(NrHosts);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] owner_q, owner_d;
    logic [PtrW-1:0] winner;
    logic            found;
    logic            accept;
    logic            timeout_hit;

    logic [3:0]              be_arr    [NrHosts];
    logic [AddressWidth-1:0] addr_arr  [NrHosts];
    logic [DataWidth-1:0]    wdata_arr [NrHosts];

    for (genvar g = 0; g < NrHosts; g++) begin : g_unpack
        assign be_arr[g]    = host_be_i[4*g +: 4];
        assign addr_arr[g]  = host_addr_i[AddressWidth*g +: AddressWidth];
        assign wdata_arr[g] = host_wdata_i[DataWidth*g +: DataWidth];
    end

    // Scan from the priority pointer, wrapping at NrHosts-1; the first requester wins.
    always_comb begin
        logic [PtrW-1:0] idx;
        // NOTE: combinational logic uses blocking '=' and assigns every output a default
        // first, so no latch is inferred; only the always_ff below uses '<='.
        idx    = ptr_q;
        winner = ptr_q;
        found  = 1'b0;
        for (int i = 0; i < NrHosts; i++) begin
            if (!found && host_req_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = (idx == PtrW'(NrHosts - 1)) ? '0 : idx + PtrW'(1);
        end
    end

`ifdef HOST_ARB_TIMEOUT_EN
    localparam int CntW = ($clog2(TimeoutCycles + 1) > 8) ? $clog2(TimeoutCycles + 1) : 8;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == CntW'(TimeoutCycles));

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == WAIT_RESP) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TimeoutCycles != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        accept        = 1'b0;
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        dev_req_o     = 1'b0;
        dev_we_o      = 1'b0;
        dev_be_o      = '0;
        dev_addr_o    = '0;
        dev_wdata_o   = '0;

        unique case (state_q)
            IDLE: begin
                // NOTE: the request path is combinational from the host inputs, so it is
                // gated with rst_ni to keep every output at 0 while reset is held.
                if (found && rst_ni) begin
                    dev_req_o   = 1'b1;
                    dev_we_o    = host_we_i[winner];
                    dev_be_o    = be_arr[winner];
                    dev_addr_o  = addr_arr[winner];
                    dev_wdata_o = wdata_arr[winner];
                    if (dev_gnt_i) begin
                        accept             = 1'b1;
                        host_gnt_o[winner] = 1'b1;
                        owner_d            = winner;
                        ptr_d              = (winner == PtrW'(NrHosts - 1)) ? '0 : winner + PtrW'(1);
                        state_d            = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                // A real response wins over a timeout landing in the same cycle.
                if (dev_rvalid_i || timeout_hit) begin
                    host_rvalid_o[owner_q] = 1'b1;
                    host_err_o[owner_q]    = dev_rvalid_i ? dev_err_i : 1'b1;
                    host_rdata_o           = dev_rvalid_i ? dev_rdata_i : '0;
                    state_d                = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_host_arbiter.sv
// Self-checking bench for host_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a transaction-level model.
module tb_host_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

`ifdef HOST_ARB_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    host_req_i, host_we_i;
    logic [N*4-1:0]  host_be_i;
    logic [N*AW-1:0] host_addr_i;
    logic [N*DW-1:0] host_wdata_i;
    logic [N-1:0]    host_gnt_o, host_rvalid_o, host_err_o;
    logic [DW-1:0]   host_rdata_o;
    logic            dev_req_o, dev_we_o;
    logic [3:0]      dev_be_o;
    logic [AW-1:0]   dev_addr_o;
    logic [DW-1:0]   dev_wdata_o;
    logic            dev_gnt_i, dev_rvalid_i, dev_err_i;
    logic [DW-1:0]   dev_rdata_i;

    host_arbiter #(
        .NrHosts      (N),
        .DataWidth    (DW),
        .AddressWidth (AW),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .host_req_i   (host_req_i),
        .host_we_i    (host_we_i),
        .host_be_i    (host_be_i),
        .host_addr_i  (host_addr_i),
        .host_wdata_i (host_wdata_i),
        .host_gnt_o   (host_gnt_o),
        .host_rvalid_o(host_rvalid_o),
        .host_rdata_o (host_rdata_o),
        .host_err_o   (host_err_o),
        .dev_req_o    (dev_req_o),
        .dev_we_o     (dev_we_o),
        .dev_be_o     (dev_be_o),
        .dev_addr_o   (dev_addr_o),
        .dev_wdata_o  (dev_wdata_o),
        .dev_gnt_i    (dev_gnt_i),
        .dev_rvalid_i (dev_rvalid_i),
        .dev_rdata_i  (dev_rdata_i),
        .dev_err_i    (dev_err_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        host_req_i   = '0;
        host_we_i    = '0;
        host_be_i    = '0;
        host_addr_i  = '0;
        host_wdata_i = '0;
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b0;
        dev_err_i    = 1'b0;
        dev_rdata_i  = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},    64'(host_gnt_o),    64'(0));
        check({tag, "_rvalid"}, 64'(host_rvalid_o), 64'(0));
        check({tag, "_err"},    64'(host_err_o),    64'(0));
        check({tag, "_rdata"},  64'(host_rdata_o),  64'(0));
        check({tag, "_dreq"},   64'(dev_req_o),     64'(0));
        check({tag, "_dwe"},    64'(dev_we_o),      64'(0));
        check({tag, "_dbe"},    64'(dev_be_o),      64'(0));
        check({tag, "_daddr"},  64'(dev_addr_o),    64'(0));
        check({tag, "_dwdata"}, 64'(dev_wdata_o),   64'(0));
    endtask

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
        logic [1:0]  e_gnt;
        logic        e_dreq;
        logic [31:0] e_addr;
        logic [1:0]  e_rv;
        logic [1:0]  e_err;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        logic [N-1:0]  gnt, rvalid, err;
        logic [DW-1:0] rdata;
        logic          dreq, dwe;
        logic [3:0]    dbe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwdata;
        logic          resp;
    } exp_t;

    // Transaction-level reference: busy flag, owner, next-priority host, cycles spent waiting.
    int m_busy, m_owner, m_ptr, m_wait;

    task automatic model_eval(output exp_t e, output int w);
        e = '{default: '0};
        w = -1;
        if (m_busy == 0) begin
            for (int k = 0; k < N; k++) begin
                int h;
                h = (m_ptr + k) % N;
                if (w < 0 && host_req_i[h]) w = h;
            end
            if (w >= 0) begin
                e.dreq   = 1'b1;
                e.dwe    = host_we_i[w];
                e.dbe    = host_be_i[w*4 +: 4];
                e.daddr  = host_addr_i[w*AW +: AW];
                e.dwdata = host_wdata_i[w*DW +: DW];
                if (dev_gnt_i) e.gnt[w] = 1'b1;
            end
        end else if (dev_rvalid_i) begin
            e.resp           = 1'b1;
            e.rvalid[m_owner] = 1'b1;
            e.err[m_owner]    = dev_err_i;
            e.rdata          = dev_rdata_i;
        end else if (TimeoutOn && m_wait == TO) begin
            e.resp           = 1'b1;
            e.rvalid[m_owner] = 1'b1;
            e.err[m_owner]    = 1'b1;
        end
    endtask

    task automatic model_step(input exp_t e, input int w);
        if (m_busy == 0) begin
            if (w >= 0 && dev_gnt_i) begin
                m_busy  = 1;
                m_owner = w;
                m_ptr   = (w + 1) % N;
                m_wait  = 0;
            end
        end else if (e.resp) begin
            m_busy = 0;
        end else begin
            m_wait++;
        end
    endtask

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h1000_0100;

    vec_t vt[13];

    initial begin
        exp_t e;
        int   w;
        int   seen;

        // Table: alternation, ignored idle response, stalled grant, dropped request.
        //          req    g     rv    err   rdata          e_gnt  dreq  e_addr  e_rv   e_err  e_rdata
        vt[0]  = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h0,         2'b01, 1'b1, A0,     2'b00, 2'b00, 32'h0};
        vt[1]  = '{2'b11, 1'b1, 1'b1, 1'b0, 32'h1111_1111, 2'b00, 1'b0, 32'h0,  2'b01, 2'b00, 32'h1111_1111};
        vt[2]  = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h0,         2'b10, 1'b1, A1,     2'b00, 2'b00, 32'h0};
        vt[3]  = '{2'b11, 1'b1, 1'b1, 1'b0, 32'h2222_2222, 2'b00, 1'b0, 32'h0,  2'b10, 2'b00, 32'h2222_2222};
        vt[4]  = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h0,         2'b01, 1'b1, A0,     2'b00, 2'b00, 32'h0};
        vt[5]  = '{2'b11, 1'b1, 1'b1, 1'b0, 32'h3333_3333, 2'b00, 1'b0, 32'h0,  2'b01, 2'b00, 32'h3333_3333};
        vt[6]  = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h0,         2'b10, 1'b1, A1,     2'b00, 2'b00, 32'h0};
        vt[7]  = '{2'b11, 1'b1, 1'b1, 1'b1, 32'h4444_4444, 2'b00, 1'b0, 32'h0,  2'b10, 2'b10, 32'h4444_4444};
        vt[8]  = '{2'b00, 1'b1, 1'b1, 1'b1, 32'h5555_5555, 2'b00, 1'b0, 32'h0,  2'b00, 2'b00, 32'h0};
        vt[9]  = '{2'b01, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b1, A0,     2'b00, 2'b00, 32'h0};
        vt[10] = '{2'b10, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b1, A1,     2'b00, 2'b00, 32'h0};
        vt[11] = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h0,         2'b01, 1'b1, A0,     2'b00, 2'b00, 32'h0};
        vt[12] = '{2'b00, 1'b0, 1'b1, 1'b1, 32'h6666_6666, 2'b00, 1'b0, 32'h0,  2'b01, 2'b01, 32'h6666_6666};

        // Reset asserted with every input active: all outputs must be 0.
        rst_ni       = 1'b0;
        host_req_i   = '1;
        host_we_i    = '1;
        host_be_i    = '1;
        host_addr_i  = '1;
        host_wdata_i = '1;
        dev_gnt_i    = 1'b1;
        dev_rvalid_i = 1'b1;
        dev_err_i    = 1'b1;
        dev_rdata_i  = '1;
        #2;
        check_all_zero("rst_active");
        next_cycle();
        rst_ni       = 1'b1;
        host_req_i   = 2'b11;
        dev_rvalid_i = 1'b0;
        dev_err_i    = 1'b0;
        sample();
        check("rst_first_gnt", 64'(host_gnt_o), 64'(2'b01));
        next_cycle();
        dev_rvalid_i = 1'b1;
        host_req_i   = '0;
        sample();
        check("rst_first_rvalid", 64'(host_rvalid_o), 64'(2'b01));
        next_cycle();

        do_reset();
        host_addr_i = {A1, A0};
        for (int i = 0; i < 13; i++) begin
            host_req_i   = vt[i].req;
            dev_gnt_i    = vt[i].gnt;
            dev_rvalid_i = vt[i].rvalid;
            dev_err_i    = vt[i].err;
            dev_rdata_i  = vt[i].rdata;
            sample();
            check($sformatf("vec%0d_gnt", i),    64'(host_gnt_o),    64'(vt[i].e_gnt));
            check($sformatf("vec%0d_dreq", i),   64'(dev_req_o),     64'(vt[i].e_dreq));
            check($sformatf("vec%0d_daddr", i),  64'(dev_addr_o),    64'(vt[i].e_addr));
            check($sformatf("vec%0d_rvalid", i), 64'(host_rvalid_o), 64'(vt[i].e_rv));
            check($sformatf("vec%0d_err", i),    64'(host_err_o),    64'(vt[i].e_err));
            check($sformatf("vec%0d_rdata", i),  64'(host_rdata_o),  64'(vt[i].e_rdata));
            next_cycle();
        end

        // Host1 read stalled three cycles by the device.
        clear_inputs();
        host_req_i  = 2'b10;
        host_addr_i = {32'h0020_0004, 32'h0};
        for (int i = 0; i < 3; i++) begin
            sample();
            check("stall_gnt",   64'(host_gnt_o), 64'(0));
            check("stall_dreq",  64'(dev_req_o),  64'(1));
            check("stall_daddr", 64'(dev_addr_o), 64'(32'h0020_0004));
            next_cycle();
        end
        dev_gnt_i = 1'b1;
        sample();
        check("stall_gnt_final", 64'(host_gnt_o), 64'(2'b10));
        next_cycle();
        clear_inputs();
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'hDEAD_BEEF;
        sample();
        check("stall_rvalid", 64'(host_rvalid_o), 64'(2'b10));
        check("stall_rdata",  64'(host_rdata_o),  64'(32'hDEAD_BEEF));
        next_cycle();
        dev_rvalid_i = 1'b0;
        sample();
        check("post_resp_rdata",  64'(host_rdata_o),  64'(0));
        check("post_resp_rvalid", 64'(host_rvalid_o), 64'(0));
        next_cycle();

        // Host0 partial write answered with an error.
        host_req_i   = 2'b01;
        host_we_i    = 2'b01;
        host_be_i    = 8'b0000_0011;
        host_wdata_i = {32'hFFFF_FFFF, 32'h1234_5678};
        dev_gnt_i    = 1'b1;
        sample();
        check("wr_gnt",    64'(host_gnt_o),  64'(2'b01));
        check("wr_dwe",    64'(dev_we_o),    64'(1));
        check("wr_dbe",    64'(dev_be_o),    64'(4'b0011));
        check("wr_dwdata", 64'(dev_wdata_o), 64'(32'h1234_5678));
        next_cycle();
        clear_inputs();
        dev_rvalid_i = 1'b1;
        dev_err_i    = 1'b1;
        sample();
        check("wr_rvalid", 64'(host_rvalid_o), 64'(2'b01));
        check("wr_err",    64'(host_err_o),    64'(2'b01));
        next_cycle();

        // Device accepts but never responds.
        clear_inputs();
        host_req_i = 2'b01;
        dev_gnt_i  = 1'b1;
        sample();
        check("to_gnt", 64'(host_gnt_o), 64'(2'b01));
        next_cycle();
        clear_inputs();
`ifdef HOST_ARB_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            sample();
            check("to_wait_rvalid", 64'(host_rvalid_o), 64'(0));
            next_cycle();
        end
        sample();
        check("to_rvalid", 64'(host_rvalid_o), 64'(2'b01));
        check("to_err",    64'(host_err_o),    64'(2'b01));
        check("to_rdata",  64'(host_rdata_o),  64'(0));
        next_cycle();
        sample();
        check("to_after_rvalid", 64'(host_rvalid_o), 64'(0));
        next_cycle();
`else
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            sample();
            if (host_rvalid_o != 0 || dev_req_o) seen++;
            next_cycle();
        end
        check("no_timeout_activity", 64'(seen), 64'(0));
`endif

        // Reset pulsed while a transaction is outstanding.
        do_reset();
        host_req_i = 2'b10;
        dev_gnt_i  = 1'b1;
        sample();
        check("abort_gnt", 64'(host_gnt_o), 64'(2'b10));
        next_cycle();
        clear_inputs();
        next_cycle();
        rst_ni = 1'b0;
        #2;
        check("abort_in_rst_dreq",   64'(dev_req_o),     64'(0));
        check("abort_in_rst_rvalid", 64'(host_rvalid_o), 64'(0));
        next_cycle();
        rst_ni       = 1'b1;
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'h0000_0ABC;
        sample();
        check("abort_late_rvalid", 64'(host_rvalid_o), 64'(0));
        check("abort_late_rdata",  64'(host_rdata_o),  64'(0));
        next_cycle();
        dev_rvalid_i = 1'b0;
        host_req_i   = 2'b11;
        dev_gnt_i    = 1'b1;
        sample();
        check("abort_next_gnt", 64'(host_gnt_o), 64'(2'b01));
        next_cycle();
        clear_inputs();
        dev_rvalid_i = 1'b1;
        sample();
        check("abort_next_rvalid", 64'(host_rvalid_o), 64'(2'b01));
        next_cycle();

        // Random traffic against the reference model.
        do_reset();
        m_busy  = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_wait  = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            host_req_i   = 2'($urandom);
            host_we_i    = 2'($urandom);
            host_be_i    = 8'($urandom);
            host_addr_i  = {$urandom, $urandom};
            host_wdata_i = {$urandom, $urandom};
            dev_gnt_i    = ($urandom_range(0, 3) != 0);
            dev_rvalid_i = ($urandom_range(0, 2) == 0);
            dev_err_i    = 1'($urandom);
            dev_rdata_i  = $urandom;
            model_eval(e, w);
            sample();
            check("rnd_gnt",    64'(host_gnt_o),    64'(e.gnt));
            check("rnd_rvalid", 64'(host_rvalid_o), 64'(e.rvalid));
            check("rnd_err",    64'(host_err_o),    64'(e.err));
            check("rnd_rdata",  64'(host_rdata_o),  64'(e.rdata));
            check("rnd_dreq",   64'(dev_req_o),     64'(e.dreq));
            check("rnd_dwe",    64'(dev_we_o),      64'(e.dwe));
            check("rnd_dbe",    64'(dev_be_o),      64'(e.dbe));
            check("rnd_daddr",  64'(dev_addr_o),    64'(e.daddr));
            check("rnd_dwdata", 64'(dev_wdata_o),   64'(e.dwdata));
            model_step(e, w);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
